// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-port, byte-addressed, big-endian word memory between the instruction-fetch
// port (IF) and the data port (DM). Level requests are sampled in IDLE, one port is granted,
// the memory is held for MEM_LATENCY cycles, and the owner then sees a 1-cycle ready pulse.
// A RESP cycle follows every access so a requester can drop its request before the next grant.
//
// Optional feature (macro MEM_ARB_RR_EN):
//   defined   : round-robin arbitration. On contention the port that was not granted last wins.
//   undefined : fixed priority, DM over IF. No pointer register exists.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   i_if_req        IF read request, held until o_if_ready
//   i_if_addr       IF word address (bits [1:0] are ignored)
//   o_if_ready      1-cycle pulse, o_if_rdata valid
//   o_if_rdata      fetched instruction word
//   i_dm_req        DM request, held until o_dm_ready
//   i_dm_wr         DM direction, 1 = write
//   i_dm_addr       DM word address
//   i_dm_wdata      DM write data
//   o_dm_ready      1-cycle pulse, access complete / o_dm_rdata valid
//   o_dm_rdata      DM read data, holds its last value on writes and errors
//   o_dm_err        valid with o_dm_ready: misaligned access, not performed
//   o_mem_en        memory access active
//   o_mem_wr        memory write strobe, final access cycle only
//   o_mem_addr      memory address
//   o_mem_wdata     memory write data
//   i_mem_rdata     memory read data, valid by the final access cycle
// ---------------------------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ready,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_dm_req,
    input  logic              i_dm_wr,
    input  logic [ADDR_W-1:0] i_dm_addr,
    input  logic [DATA_W-1:0] i_dm_wdata,
    output logic              o_dm_ready,
    output logic [DATA_W-1:0] o_dm_rdata,
    output logic              o_dm_err,
    output logic              o_mem_en,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    // State and registered outputs
    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_owner_dm;
    logic              r_wr;
    logic              r_if_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_dm_ready;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_dm_err;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;

    // Next-state values
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_owner_dm_nxt;
    logic              w_wr_nxt;
    logic              w_if_ready_nxt;
    logic [DATA_W-1:0] w_if_rdata_nxt;
    logic              w_dm_ready_nxt;
    logic [DATA_W-1:0] w_dm_rdata_nxt;
    logic              w_dm_err_nxt;
    logic              w_mem_en_nxt;
    logic              w_mem_wr_nxt;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;

    logic              w_any_req;
    logic              w_grant_dm;
    logic              w_dm_misaligned;
    logic [ADDR_W-1:0] w_if_addr_word;

    assign w_any_req       = i_if_req | i_dm_req;
    assign w_dm_misaligned = (i_dm_addr[1:0] != 2'b00);
    // IF is assumed aligned; force it onto a word boundary anyway.
    assign w_if_addr_word  = i_if_addr & ~(ADDR_W'(3));

`ifdef MEM_ARB_RR_EN
    // Owner of the most recent grant; reset value IF, so the first contention goes to DM.
    logic r_last_dm;
    logic w_last_dm_nxt;

    always_comb begin
        if (i_if_req && i_dm_req) begin
            w_grant_dm = ~r_last_dm;
        end else begin
            w_grant_dm = i_dm_req;
        end
    end

    assign w_last_dm_nxt = (r_state == IDLE && w_any_req) ? w_grant_dm : r_last_dm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_dm <= 1'b0;
        end else begin
            r_last_dm <= w_last_dm_nxt;
        end
    end
`else
    assign w_grant_dm = i_dm_req;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_owner_dm_nxt  = r_owner_dm;
        w_wr_nxt        = r_wr;
        w_if_ready_nxt  = 1'b0;
        w_if_rdata_nxt  = r_if_rdata;
        w_dm_ready_nxt  = 1'b0;
        w_dm_rdata_nxt  = r_dm_rdata;
        w_dm_err_nxt    = 1'b0;
        w_mem_en_nxt    = r_mem_en;
        w_mem_wr_nxt    = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;

        case (r_state)
            IDLE: begin
                if (w_any_req) begin
                    w_owner_dm_nxt = w_grant_dm;
                    w_wr_nxt       = w_grant_dm & i_dm_wr;
                    if (w_grant_dm && w_dm_misaligned) begin
                        // Rejected without touching the memory.
                        w_mem_en_nxt   = 1'b0;
                        w_dm_ready_nxt = 1'b1;
                        w_dm_err_nxt   = 1'b1;
                        w_state_nxt    = RESP;
                    end else begin
                        w_mem_en_nxt    = 1'b1;
                        w_mem_addr_nxt  = w_grant_dm ? i_dm_addr : w_if_addr_word;
                        w_mem_wdata_nxt = w_grant_dm ? i_dm_wdata : '0;
                        w_cnt_nxt       = CNT_W'(MEM_LATENCY - 1);
                        // With a single-cycle memory the first ACC cycle is already the last.
                        w_mem_wr_nxt    = w_grant_dm && i_dm_wr && (MEM_LATENCY == 1);
                        w_state_nxt     = ACC;
                    end
                end
            end

            ACC: begin
                if (r_cnt == '0) begin
                    w_mem_en_nxt = 1'b0;
                    if (r_owner_dm) begin
                        w_dm_ready_nxt = 1'b1;
                        if (!r_wr) begin
                            w_dm_rdata_nxt = i_mem_rdata;
                        end
                    end else begin
                        w_if_ready_nxt = 1'b1;
                        w_if_rdata_nxt = i_mem_rdata;
                    end
                    w_state_nxt = RESP;
                end else begin
                    w_cnt_nxt    = r_cnt - CNT_W'(1);
                    // Registered strobe: raise it for the cycle in which r_cnt will read 0.
                    w_mem_wr_nxt = r_wr && (r_cnt == CNT_W'(1));
                end
            end

            RESP: begin
                // Turnaround cycle, no grant.
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt  = IDLE;
                w_mem_en_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_owner_dm  <= 1'b0;
            r_wr        <= 1'b0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_ready  <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_err    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_owner_dm  <= w_owner_dm_nxt;
            r_wr        <= w_wr_nxt;
            r_if_ready  <= w_if_ready_nxt;
            r_if_rdata  <= w_if_rdata_nxt;
            r_dm_ready  <= w_dm_ready_nxt;
            r_dm_rdata  <= w_dm_rdata_nxt;
            r_dm_err    <= w_dm_err_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    assign o_if_ready  = r_if_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_ready  = r_dm_ready;
    assign o_dm_rdata  = r_dm_rdata;
    assign o_dm_err    = r_dm_err;
    assign o_mem_en    = r_mem_en;
    assign o_mem_wr    = r_mem_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
